lat_i2c_regbank: RTL and testbench
==================================

# lat_i2c_regbank

Register-bank front end for the Lattice I2C master controller. It decodes a simple byte-wide register bus (`addr`/`we`/`re`) into the controller's configuration inputs, holds the start request until the controller acknowledges it, and buffers the data path both ways. Transmit bytes pass through a small TX FIFO; received bytes pass through a small RX FIFO. It sits directly upstream of the controller, between the host/testbench bus and the controller's register-side ports.

## Interface
Parameters:
- `TX_DEPTH`, 4, TX FIFO depth in bytes; power of two, 2..16.
- `RX_DEPTH`, 4, RX FIFO depth in bytes; power of two, 2..16.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `addr`  in  4  register address.
- `we`  in  1  write strobe, one cycle per access.
- `re`  in  1  read strobe, one cycle per access.
- `wdata`  in  8  write data.
- `rdata`  out  8  read data, registered.
- `i_slave_addr_reg`  out  10  to controller.
- `i_byte_cnt_reg`  out  8  to controller.
- `i_clk_div_lsb`  out  8  to controller.
- `i_config_reg`  out  6  to controller.
- `i_mode_reg`  out  8  to controller.
- `o_cmd_status_reg`  in  8  from controller.
- `o_start_ack`  in  1  from controller.
- `i_transmit_data`  out  8  TX FIFO head to controller.
- `o_transmit_data_request`  in  1  from controller.
- `o_received_data_valid`  in  1  from controller.
- `o_receive_data`  in  8  from controller.

## Operation
- Register map (R = read, W = write):
  - 0x0 SADDR_L (RW): `i_slave_addr_reg[7:0]`.
  - 0x1 SADDR_H (RW): bits [1:0] → `[9:8]`.
  - 0x2 BYTE_CNT (RW).
  - 0x3 CLK_DIV (RW).
  - 0x4 MODE (RW).
  - 0x5 CONFIG (RW).
  - 0x6 STATUS (R): `o_cmd_status_reg`.
  - 0x7 TXDATA (W): push to TX FIFO.
  - 0x8 RXDATA (R): pop from RX FIFO.
  - 0x9 FIFO_STAT (R): {2'b0, rx_ovf, tx_udr, rx_full, rx_empty, tx_full, tx_empty}.
  - Other addresses read 0x00 and ignore writes.
- CONFIG bits: [5] start, [4] soft_reset, [3] abort, [2] tx_ie, [1] rx_ie, [0] int_en.
  - start: set by a write of 1; holds until the cycle after `o_start_ack`=1, then clears. A write of 0 cannot clear a pending start.
  - soft_reset and abort: single-cycle pulses that self-clear on the next cycle.
  - soft_reset also flushes both FIFOs and clears the sticky flags. Register values are kept.
- TX FIFO (show-ahead):
  - `i_transmit_data` = head byte, or 0x00 when empty.
  - Pop on each rising edge of `o_transmit_data_request`.
  - Request edge while empty: no pop; set sticky tx_udr.
  - Push while full, with no pop in the same cycle: byte dropped.
- RX FIFO:
  - Push `o_receive_data` on each rising edge of `o_received_data_valid`.
  - Push while full: byte dropped; set sticky rx_ovf.
  - RXDATA read while empty returns 0x00; pointers unchanged.
- Push and pop in the same cycle are both performed; the count is unchanged. This holds for a full FIFO too (pop frees the slot).
- A read of FIFO_STAT clears tx_udr and rx_ovf. A flag event in the same cycle as that read wins; the flag stays set.
- `we` and `re` in the same cycle are both honoured.

## Timing
- Reset values: all outputs 0x00 / 0, FIFOs empty, flags clear.
- Reset is asynchronous and may arrive mid-transfer; FIFO contents are discarded.
- Write → output register updates one cycle after `we`.
- `rdata` is valid one cycle after `re` and holds its value until the next `re`.
- RXDATA pop takes effect in the same cycle as the read.
- Rising-edge detectors use one registered copy of each controller strobe, so the event acts one cycle after the input rises.
- Start: `i_config_reg[5]` rises one cycle after the write and falls one cycle after `o_start_ack`.

## Configuration
- `LAT_REGBANK_IRQ_EN` defined:
  - Adds port `o_irq`  out  1.
  - `o_irq` = int_en & ((rx_ie & ~rx_empty) | (tx_ie & tx_empty) | tx_udr | rx_ovf).
  - `o_irq` is registered; reset value 0.
- Macro undefined: port and logic are absent; all other behaviour is identical.

## Structure
- Package `lat_regbank_pkg`:
  - register address localparams;
  - CONFIG bit-index localparams;
  - FIFO_STAT bit indices.
- Sub-module `lat_sync_fifo`: parameterised width and depth, show-ahead, with full/empty outputs. It is instantiated twice (TX and RX).

## Test plan
- Reset → every output 0; FIFO_STAT read returns 0x05.
- Write SADDR_L=0x5A, SADDR_H=0x03, MODE=0x81 → `i_slave_addr_reg`=0x35A and `i_mode_reg`=0x81 one cycle later; readback matches.
- Write CONFIG=0x20 → bit 5 stays high; assert `o_start_ack` 3 cycles later → bit 5 clears on the following cycle.
- Push 0x11, 0x22; pulse `o_transmit_data_request` three times → `i_transmit_data` shows 0x11, then 0x22, then 0x00; FIFO_STAT reads tx_udr=1; a second read reads 0.
- Pulse `o_received_data_valid` 5 times with data 0xA0..0xA4 (RX_DEPTH=4) → RXDATA reads return 0xA0..0xA3 then 0x00; rx_ovf=1.
- With TX FIFO full, a TXDATA write coincides with a request edge → new byte accepted; count stays at 4; no flag set.

Source files
------------

// File: rtl/lat_regbank_pkg.sv
// +----------------------------------------------------------------------------+
// | lat_regbank_pkg                                                            |
// | Register map, CONFIG and FIFO_STAT bit indices for lat_i2c_regbank.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package lat_regbank_pkg;

  localparam logic [3:0] c_addr_saddr_l   = 4'h0;
  localparam logic [3:0] c_addr_saddr_h   = 4'h1;
  localparam logic [3:0] c_addr_byte_cnt  = 4'h2;
  localparam logic [3:0] c_addr_clk_div   = 4'h3;
  localparam logic [3:0] c_addr_mode      = 4'h4;
  localparam logic [3:0] c_addr_config    = 4'h5;
  localparam logic [3:0] c_addr_status    = 4'h6;
  localparam logic [3:0] c_addr_txdata    = 4'h7;
  localparam logic [3:0] c_addr_rxdata    = 4'h8;
  localparam logic [3:0] c_addr_fifo_stat = 4'h9;

  localparam int c_cfg_start      = 5;
  localparam int c_cfg_soft_reset = 4;
  localparam int c_cfg_abort      = 3;
  localparam int c_cfg_tx_ie      = 2;
  localparam int c_cfg_rx_ie      = 1;
  localparam int c_cfg_int_en     = 0;

  localparam int c_fs_tx_empty = 0;
  localparam int c_fs_tx_full  = 1;
  localparam int c_fs_rx_empty = 2;
  localparam int c_fs_rx_full  = 3;
  localparam int c_fs_tx_udr   = 4;
  localparam int c_fs_rx_ovf   = 5;

endpackage

`default_nettype wire

// File: rtl/lat_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | lat_sync_fifo                                                              |
// | Show-ahead synchronous FIFO with flush; simultaneous push/pop when full.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module lat_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == c_depth);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rptr];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_do_pop)  r_rptr <= r_rptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/lat_i2c_regbank.sv
// +----------------------------------------------------------------------------+
// | lat_i2c_regbank                                                            |
// | Register bank, start handshake and TX/RX FIFOs for the I2C master.         |
// | Optional interrupt output: define LAT_REGBANK_IRQ_EN.                      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module lat_i2c_regbank
  import lat_regbank_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] addr,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic [9:0] i_slave_addr_reg,
  output logic [7:0] i_byte_cnt_reg,
  output logic [7:0] i_clk_div_lsb,
  output logic [5:0] i_config_reg,
  output logic [7:0] i_mode_reg,
  input  logic [7:0] o_cmd_status_reg,
  input  logic       o_start_ack,
  output logic [7:0] i_transmit_data,
  input  logic       o_transmit_data_request,
  input  logic       o_received_data_valid,
  input  logic [7:0] o_receive_data
`ifdef LAT_REGBANK_IRQ_EN
  ,
  output logic       o_irq
`endif
);

  logic [9:0] r_saddr;
  logic [7:0] r_byte_cnt;
  logic [7:0] r_clk_div;
  logic [7:0] r_mode;
  logic [2:0] r_cfg_lo;
  logic       r_start;
  logic       r_soft;
  logic       r_abort;
  logic       r_tx_udr;
  logic       r_rx_ovf;
  logic       r_req_d;
  logic       r_val_d;
  logic [7:0] r_rdata;

  logic       w_wr_cfg;
  logic       w_tx_push;
  logic       w_req_rise;
  logic       w_val_rise;
  logic       w_rx_pop;
  logic       w_stat_rd;
  logic       w_udr_evt;
  logic       w_ovf_evt;
  logic [7:0] w_tx_head;
  logic [7:0] w_rx_head;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic [7:0] w_fifo_stat;
  logic [7:0] w_rd_mux;

  assign w_wr_cfg   = we & (addr == c_addr_config);
  assign w_tx_push  = we & (addr == c_addr_txdata);
  assign w_rx_pop   = re & (addr == c_addr_rxdata) & ~w_rx_empty;
  assign w_stat_rd  = re & (addr == c_addr_fifo_stat);
  assign w_req_rise = o_transmit_data_request & ~r_req_d;
  assign w_val_rise = o_received_data_valid & ~r_val_d;
  assign w_udr_evt  = w_req_rise & w_tx_empty;
  assign w_ovf_evt  = w_val_rise & w_rx_full & ~w_rx_pop;

  assign i_slave_addr_reg = r_saddr;
  assign i_byte_cnt_reg   = r_byte_cnt;
  assign i_clk_div_lsb    = r_clk_div;
  assign i_mode_reg       = r_mode;
  assign i_config_reg     = {r_start, r_soft, r_abort, r_cfg_lo};
  assign i_transmit_data  = w_tx_empty ? 8'h00 : w_tx_head;
  assign rdata            = r_rdata;

  assign w_fifo_stat = {2'b00, r_rx_ovf, r_tx_udr, w_rx_full, w_rx_empty,
                        w_tx_full, w_tx_empty};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_saddr    <= '0;
      r_byte_cnt <= '0;
      r_clk_div  <= '0;
      r_mode     <= '0;
      r_cfg_lo   <= '0;
      r_start    <= 1'b0;
      r_soft     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      if (we) begin
        case (addr)
          c_addr_saddr_l:  r_saddr[7:0] <= wdata;
          c_addr_saddr_h:  r_saddr[9:8] <= wdata[1:0];
          c_addr_byte_cnt: r_byte_cnt   <= wdata;
          c_addr_clk_div:  r_clk_div    <= wdata;
          c_addr_mode:     r_mode       <= wdata;
          c_addr_config:   r_cfg_lo     <= wdata[2:0];
          default:         ;
        endcase
      end
      // Start is sticky: only the controller's ack can drop it.
      if (w_wr_cfg && wdata[c_cfg_start]) r_start <= 1'b1;
      else if (o_start_ack)               r_start <= 1'b0;
      r_soft  <= w_wr_cfg & wdata[c_cfg_soft_reset];
      r_abort <= w_wr_cfg & wdata[c_cfg_abort];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_d  <= 1'b0;
      r_val_d  <= 1'b0;
      r_tx_udr <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      r_req_d <= o_transmit_data_request;
      r_val_d <= o_received_data_valid;
      // A flag event coinciding with the clearing read keeps the flag set.
      if (w_udr_evt)              r_tx_udr <= 1'b1;
      else if (w_stat_rd | r_soft) r_tx_udr <= 1'b0;
      if (w_ovf_evt)              r_rx_ovf <= 1'b1;
      else if (w_stat_rd | r_soft) r_rx_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_rd_mux = 8'h00;
    case (addr)
      c_addr_saddr_l:   w_rd_mux = r_saddr[7:0];
      c_addr_saddr_h:   w_rd_mux = {6'b0, r_saddr[9:8]};
      c_addr_byte_cnt:  w_rd_mux = r_byte_cnt;
      c_addr_clk_div:   w_rd_mux = r_clk_div;
      c_addr_mode:      w_rd_mux = r_mode;
      c_addr_config:    w_rd_mux = i_config_reg;
      c_addr_status:    w_rd_mux = o_cmd_status_reg;
      c_addr_rxdata:    w_rd_mux = w_rx_empty ? 8'h00 : w_rx_head;
      c_addr_fifo_stat: w_rd_mux = w_fifo_stat;
      default:          w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_rdata <= 8'h00;
    else if (re) r_rdata <= w_rd_mux;
  end

`ifdef LAT_REGBANK_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else r_irq <= r_cfg_lo[c_cfg_int_en] &
                  ((r_cfg_lo[c_cfg_rx_ie] & ~w_rx_empty) |
                   (r_cfg_lo[c_cfg_tx_ie] & w_tx_empty) |
                   r_tx_udr | r_rx_ovf);
  end
  assign o_irq = r_irq;
`endif

  lat_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (r_soft),
    .i_push  (w_tx_push),
    .i_data  (wdata),
    .i_pop   (w_req_rise),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  lat_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (r_soft),
    .i_push  (w_val_rise),
    .i_data  (o_receive_data),
    .i_pop   (w_rx_pop),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_lat_i2c_regbank.sv
// +----------------------------------------------------------------------------+
// | tb_lat_i2c_regbank                                                         |
// | Directed self-checking bench for lat_i2c_regbank with a read scoreboard.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lat_i2c_regbank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] addr = '0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic [9:0] i_slave_addr_reg;
  logic [7:0] i_byte_cnt_reg;
  logic [7:0] i_clk_div_lsb;
  logic [5:0] i_config_reg;
  logic [7:0] i_mode_reg;
  logic [7:0] o_cmd_status_reg = 8'h00;
  logic       o_start_ack = 1'b0;
  logic [7:0] i_transmit_data;
  logic       o_transmit_data_request = 1'b0;
  logic       o_received_data_valid = 1'b0;
  logic [7:0] o_receive_data = 8'h00;
`ifdef LAT_REGBANK_IRQ_EN
  logic       o_irq;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] q_exp [$];

  always #5 clk = ~clk;

  lat_i2c_regbank #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .addr                    (addr),
    .we                      (we),
    .re                      (re),
    .wdata                   (wdata),
    .rdata                   (rdata),
    .i_slave_addr_reg        (i_slave_addr_reg),
    .i_byte_cnt_reg          (i_byte_cnt_reg),
    .i_clk_div_lsb           (i_clk_div_lsb),
    .i_config_reg            (i_config_reg),
    .i_mode_reg              (i_mode_reg),
    .o_cmd_status_reg        (o_cmd_status_reg),
    .o_start_ack             (o_start_ack),
    .i_transmit_data         (i_transmit_data),
    .o_transmit_data_request (o_transmit_data_request),
    .o_received_data_valid   (o_received_data_valid),
    .o_receive_data          (o_receive_data)
`ifdef LAT_REGBANK_IRQ_EN
    ,
    .o_irq                   (o_irq)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Expected value goes into the scoreboard when the read is issued.
  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] e;
    q_exp.push_back(exp);
    @(negedge clk);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    e = q_exp.pop_front();
    check(tag, {8'h00, rdata}, {8'h00, e});
  endtask

  task automatic pulse_req();
    @(negedge clk);
    o_transmit_data_request = 1'b1;
    @(negedge clk);
    o_transmit_data_request = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_val(input logic [7:0] d);
    @(negedge clk);
    o_receive_data = d; o_received_data_valid = 1'b1;
    @(negedge clk);
    o_received_data_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_saddr", {6'b0, i_slave_addr_reg}, 16'h0000);
    check("rst_cfg", {10'b0, i_config_reg}, 16'h0000);
    check("rst_txd", {8'b0, i_transmit_data}, 16'h0000);
    check("rst_rdata", {8'b0, rdata}, 16'h0000);
    rst = 1'b1;
    rd("rst_fstat", 4'h9, 8'h05);

    // Register writes and readback
    wr(4'h0, 8'h5A);
    wr(4'h1, 8'h03);
    wr(4'h4, 8'h81);
    check("saddr", {6'b0, i_slave_addr_reg}, 16'h035A);
    check("mode", {8'b0, i_mode_reg}, 16'h0081);
    wr(4'h2, 8'h10);
    wr(4'h3, 8'h22);
    check("bcnt", {8'b0, i_byte_cnt_reg}, 16'h0010);
    check("cdiv", {8'b0, i_clk_div_lsb}, 16'h0022);
    rd("rb_saddr_l", 4'h0, 8'h5A);
    rd("rb_saddr_h", 4'h1, 8'h03);
    rd("rb_mode", 4'h4, 8'h81);
    rd("rb_clkdiv", 4'h3, 8'h22);
    o_cmd_status_reg = 8'hC3;
    rd("rb_status", 4'h6, 8'hC3);
    rd("rb_unmapped", 4'hA, 8'h00);
    rd("rb_txdata_wo", 4'h7, 8'h00);

    // Start handshake
    wr(4'h5, 8'h20);
    check("start_set", {15'b0, i_config_reg[5]}, 16'h0001);
    repeat (3) @(negedge clk);
    check("start_hold", {15'b0, i_config_reg[5]}, 16'h0001);
    wr(4'h5, 8'h00);
    check("start_nowrclr", {15'b0, i_config_reg[5]}, 16'h0001);
    o_start_ack = 1'b1;
    @(negedge clk);
    o_start_ack = 1'b0;
    check("start_clr", {15'b0, i_config_reg[5]}, 16'h0000);

    // TX FIFO order and underflow
    wr(4'h7, 8'h11);
    wr(4'h7, 8'h22);
    check("tx_head0", {8'b0, i_transmit_data}, 16'h0011);
    pulse_req();
    check("tx_head1", {8'b0, i_transmit_data}, 16'h0022);
    pulse_req();
    check("tx_head2", {8'b0, i_transmit_data}, 16'h0000);
    pulse_req();
    rd("tx_udr_set", 4'h9, 8'h15);
    rd("tx_udr_clr", 4'h9, 8'h05);

    // RX FIFO overflow and drain
    for (int i = 0; i < 5; i++) pulse_val(8'hA0 + 8'(i));
    rd("rx_ovf_set", 4'h9, 8'h29);
    for (int i = 0; i < 4; i++) rd("rx_data", 4'h8, 8'hA0 + 8'(i));
    rd("rx_empty_rd", 4'h8, 8'h00);
    rd("rx_after", 4'h9, 8'h05);

    // Full TX FIFO with coincident push and pop
    for (int i = 0; i < 4; i++) wr(4'h7, 8'hB0 + 8'(i));
    rd("tx_full", 4'h9, 8'h06);
    @(negedge clk);
    addr = 4'h7; wdata = 8'hB4; we = 1'b1; o_transmit_data_request = 1'b1;
    @(negedge clk);
    we = 1'b0; o_transmit_data_request = 1'b0;
    check("txpp_head", {8'b0, i_transmit_data}, 16'h00B1);
    rd("txpp_stat", 4'h9, 8'h06);
    for (int i = 2; i < 5; i++) begin
      pulse_req();
      check("txpp_drain", {8'b0, i_transmit_data}, {8'h00, 8'hB0 + 8'(i)});
    end
    pulse_req();
    check("txpp_end", {8'b0, i_transmit_data}, 16'h0000);

    // Soft reset flushes FIFOs, keeps registers
    wr(4'h7, 8'h77);
    pulse_val(8'h66);
    wr(4'h5, 8'h17);
    check("soft_pulse", {10'b0, i_config_reg}, 16'h0017);
    @(negedge clk);
    check("soft_clr", {10'b0, i_config_reg}, 16'h0007);
    check("soft_txd", {8'b0, i_transmit_data}, 16'h0000);
    rd("soft_fstat", 4'h9, 8'h05);
    rd("soft_keep", 4'h0, 8'h5A);
`ifdef LAT_REGBANK_IRQ_EN
    check("irq_tx_empty", {15'b0, o_irq}, 16'h0001);
    wr(4'h5, 8'h06);
    @(negedge clk);
    check("irq_off", {15'b0, o_irq}, 16'h0000);
`endif

    // Asynchronous reset mid-transfer
    wr(4'h7, 8'h99);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_saddr", {6'b0, i_slave_addr_reg}, 16'h0000);
    check("arst_txd", {8'b0, i_transmit_data}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    rd("arst_fstat", 4'h9, 8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
